hazard_sequencer: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It watches register addresses and control bits in the ID, EX, MEM and WB stages and drives the stage enables and flushes. It also selects EX-operand forwarding and runs the start/done handshake with the multi-cycle multiply/divide unit (MDU). It sits beside the decode control block and gates every pipeline register.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_select.sv | 24 ++
 rtl/hazard_sequencer.sv | 142 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

    typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A writer matches a source only if it really writes a nonzero register.
    function automatic logic writer_match(input logic       regwrite,
                                          input logic [4:0] rd,
                                          input logic [4:0] src);
        return regwrite && (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// EX-operand forwarding mux select for one source register.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);

    // The MEM writer is younger than the WB writer, so its value wins.
    always_comb begin
        if (writer_match(mem_regwrite, mem_rd, src)) begin
            sel = FWD_EXMEM;
        end else if (writer_match(wb_regwrite, wb_rd, src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Stage enables, flushes, forwarding and MDU handshake for the five-stage core.
// Define HAZARD_FWD_EN to build with EX-operand forwarding (load-use stalls only).
module hazard_sequencer
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [4:0]             ex_rs,
    input  logic [4:0]             ex_rt,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic                   ex_branch_taken,
    input  logic                   ex_mdu_op,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_regwrite,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_regwrite,
    input  logic                   mdu_done,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   mdu_start,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t     state;
    state_t     state_eff;
    state_t     state_next;
    logic       ex_hit;
    logic       id_hazard;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    fwd_select u_fwd_a (
        .src          (ex_rs),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (sel_a)
    );

    fwd_select u_fwd_b (
        .src          (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (sel_b)
    );

    assign ex_hit = (id_use_rs && writer_match(ex_regwrite, ex_rd, id_rs)) ||
                    (id_use_rt && writer_match(ex_regwrite, ex_rd, id_rt));

`ifdef HAZARD_FWD_EN
    assign id_hazard = ex_memread && ex_hit;
    assign fwd_a     = sel_a;
    assign fwd_b     = sel_b;
`else
    logic mem_hit;
    logic unused_fwd;

    // Without bypass paths the consumer waits until the producer is in WB.
    assign mem_hit = (id_use_rs && writer_match(mem_regwrite, mem_rd, id_rs)) ||
                     (id_use_rt && writer_match(mem_regwrite, mem_rd, id_rt));
    assign id_hazard  = ex_hit || mem_hit;
    assign fwd_a      = FWD_RF;
    assign fwd_b      = FWD_RF;
    assign unused_fwd = ^{sel_a, sel_b, ex_memread};
`endif

    // Reset makes the outputs look like RUN without waiting for the edge.
    assign state_eff = rst ? RUN : state;

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_start   = 1'b0;
        state_next  = state_eff;
        case (state_eff)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mdu_op) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    mdu_start   = !rst;
                    state_next  = MDU_WAIT;
                end else if (id_hazard) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MDU_WAIT: begin
                exmem_flush = 1'b1;
                if (mdu_done) begin
                    state_next = RUN;
                end else begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (!pc_en && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_sequencer;

    localparam int STALL_CNT_W = 16;
    localparam int CNT_MAX     = (1 << STALL_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_branch_taken, ex_mdu_op;
    logic mem_regwrite, wb_regwrite, mdu_done;
    logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, mdu_start;
    logic [1:0] fwd_a, fwd_b;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [10:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: "waiting on the MDU" and the expected stall total.
    bit m_wait = 1'b0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_op(ex_mdu_op),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mdu_done(mdu_done),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .mdu_start(mdu_start), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    assign obs = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
                  mdu_start, fwd_a, fwd_b};

    function automatic bit hits(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return (we === 1'b1) && (rd != 5'd0) && (rd == src);
    endfunction

    // Expected {enables, flushes, mdu_start, fwd_a, fwd_b} from the current inputs.
    function automatic logic [10:0] model_outs();
        bit waiting, ex_w, haz, start;
        bit [2:0] en, fl;
        logic [1:0] fa, fb;
        waiting = m_wait && !rst;
        ex_w = (id_use_rs && hits(ex_regwrite, ex_rd, id_rs)) ||
               (id_use_rt && hits(ex_regwrite, ex_rd, id_rt));
`ifdef HAZARD_FWD_EN
        haz = ex_memread && ex_w;
        fa = hits(mem_regwrite, mem_rd, ex_rs) ? 2'b10 : hits(wb_regwrite, wb_rd, ex_rs) ? 2'b01 : 2'b00;
        fb = hits(mem_regwrite, mem_rd, ex_rt) ? 2'b10 : hits(wb_regwrite, wb_rd, ex_rt) ? 2'b01 : 2'b00;
`else
        haz = ex_w || (id_use_rs && hits(mem_regwrite, mem_rd, id_rs)) ||
                      (id_use_rt && hits(mem_regwrite, mem_rd, id_rt));
        fa = 2'b00;
        fb = 2'b00;
`endif
        en = 3'b111;
        fl = 3'b000;
        start = 1'b0;
        if (waiting) begin
            fl = 3'b001;
            if (!mdu_done) en = 3'b000;
        end else if (ex_branch_taken) begin
            fl = 3'b110;
        end else if (ex_mdu_op) begin
            en = 3'b000;
            fl = 3'b001;
            start = !rst;
        end else if (haz) begin
            en = 3'b001;
            fl = 3'b010;
        end
        return {en, fl, start, fa, fb};
    endfunction

    // Advance one clock, updating the reference with the inputs seen at the edge.
    task automatic tick();
        logic [10:0] e;
        e = model_outs();
        @(posedge clk);
        if (rst) begin
            m_wait = 1'b0;
            m_cnt  = 0;
        end else begin
            if (!e[10] && m_cnt < CNT_MAX) m_cnt++;
            if (!m_wait) m_wait = !ex_branch_taken && ex_mdu_op;
            else if (mdu_done) m_wait = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        ex_branch_taken = 0; ex_mdu_op = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; mdu_done = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        ex_mdu_op = 1'b1;
        #1;
        n_cmp++;
        if ({pc_en, exmem_flush, mdu_start} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_outputs: pc_en/exmem_flush/mdu_start=%b required 010",
                     {pc_en, exmem_flush, mdu_start});
        end
        tick();
        tick();
        idle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 11'b111_000_0_00_00 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outs=%b cnt=%0d required 11100000000 cnt=0", obs, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
`ifdef HAZARD_FWD_EN
        ex_regwrite = 1; ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        #1;
        n_cmp++;
        if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
            n_fail++;
            $display("FAIL load_use_stall: pc_en/ifid_en/idex_flush=%b required 001",
                     {pc_en, ifid_en, idex_flush});
        end
        tick();
        ex_regwrite = 0; ex_memread = 0; ex_rd = 0; mem_rd = 8; mem_regwrite = 1;
        #1;
        n_cmp++;
        if ({pc_en, idex_flush} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_use_release: pc_en/idex_flush=%b required 10", {pc_en, idex_flush});
        end
        tick();
        mem_rd = 0; mem_regwrite = 0; wb_rd = 8; wb_regwrite = 1; ex_rs = 8; id_use_rs = 0; id_rs = 0;
        #1;
        n_cmp++;
        if (fwd_a !== 2'b01 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_fwd: fwd_a=%b cnt=%0d required 01 cnt=1", fwd_a, stall_cnt);
        end
`else
        ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        #1;
        n_cmp++;
        if ({pc_en, idex_flush} !== 2'b01) begin
            n_fail++;
            $display("FAIL nofwd_stall_ex: pc_en/idex_flush=%b required 01", {pc_en, idex_flush});
        end
        tick();
        ex_regwrite = 0; ex_rd = 0; mem_rd = 8; mem_regwrite = 1;
        #1;
        n_cmp++;
        if ({pc_en, idex_flush} !== 2'b01) begin
            n_fail++;
            $display("FAIL nofwd_stall_mem: pc_en/idex_flush=%b required 01", {pc_en, idex_flush});
        end
        tick();
        mem_rd = 0; mem_regwrite = 0; wb_rd = 8; wb_regwrite = 1; ex_rs = 8;
        #1;
        n_cmp++;
        if ({pc_en, fwd_a} !== 3'b100 || stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL nofwd_release: pc_en/fwd_a=%b cnt=%0d required 100 cnt=2",
                     {pc_en, fwd_a}, stall_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; ex_branch_taken = 1;
        #1;
        n_cmp++;
        if (obs[10:4] !== 7'b111_110_0) begin
            n_fail++;
            $display("FAIL branch_over_hazard: en/flush/start=%b required 1111100", obs[10:4]);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL branch_no_stall: cnt=%0d required 0", stall_cnt);
        end
    endtask

    task automatic test_mdu();
        do_reset();
        mdu_done = 1'b1;
        #1;
        n_cmp++;
        if (obs[10:4] !== 7'b111_000_0) begin
            n_fail++;
            $display("FAIL mdu_done_in_run: en/flush/start=%b required 1110000", obs[10:4]);
        end
        mdu_done = 1'b0;
        ex_mdu_op = 1'b1;
        #1;
        n_cmp++;
        if (obs[10:4] !== 7'b000_001_1) begin
            n_fail++;
            $display("FAIL mdu_launch: en/flush/start=%b required 0000011", obs[10:4]);
        end
        tick();
        for (int i = 1; i <= 5; i++) begin
            mdu_done = (i == 5);
            ex_branch_taken = (i == 2);
            #1;
            n_cmp++;
            if (obs[10:4] !== {{3{i == 5}}, 3'b001, 1'b0}) begin
                n_fail++;
                $display("FAIL mdu_wait_%0d: en/flush/start=%b required %b", i, obs[10:4],
                         {{3{i == 5}}, 3'b001, 1'b0});
            end
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (obs[10:4] !== 7'b111_000_0 || stall_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL mdu_return: en/flush/start=%b cnt=%0d required 1110000 cnt=5",
                     obs[10:4], stall_cnt);
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_b;
        do_reset();
        ex_rt = 3; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
`ifdef HAZARD_FWD_EN
        exp_b = 2'b10;
`else
        exp_b = 2'b00;
`endif
        #1;
        n_cmp++;
        if (fwd_b !== exp_b) begin
            n_fail++;
            $display("FAIL fwd_mem_over_wb: fwd_b=%b required %b", fwd_b, exp_b);
        end
        ex_rt = 0; mem_rd = 0; wb_rd = 0; ex_rd = 0; ex_regwrite = 1; ex_memread = 1;
        id_rt = 0; id_use_rt = 1;
        #1;
        n_cmp++;
        if (fwd_b !== 2'b00 || pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_reg_zero: fwd_b=%b pc_en=%b required 00 1", fwd_b, pc_en);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_in_mdu();
        do_reset();
        ex_mdu_op = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mdu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mdu_start: mdu_start=%b required 0", mdu_start);
        end
        tick();
        rst = 1'b0;
        ex_mdu_op = 1'b0;
        #1;
        n_cmp++;
        if (obs[10:4] !== 7'b111_000_0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_in_mdu_wait: en/flush/start=%b cnt=%0d required 1110000 cnt=0",
                     obs[10:4], stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_mdu_op = ($urandom_range(0, 7) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
            mdu_done = ($urandom_range(0, 3) == 0);
            #1;
            n_cmp++;
            if (obs !== model_outs() || stall_cnt !== STALL_CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL random_%0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         c, obs, stall_cnt, model_outs(), m_cnt);
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mdu();
        test_forwarding();
        test_reset_in_mdu();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
